address_sequencer: RTL and testbench
====================================

// Module: address_sequencer
// PURPOSE
//  Parametrised memory-address source and sequencer for the cpu32e controller.
//  It registers the selected address source (PC, A+B, RFA, sequential) and
//  drives multi-beat bursts (load/store multiple, line fill) with a req/ack
//  handshake. It sits between the controller state logic and the memory bus
//  address mux, and supports stall, exception and interrupt suppression.
// PARAMETERS
//  ADDR_W     32  address width in bits
//  BEATS_MAX  8   maximum beats per burst (>=2)
//  STRIDE     4   byte increment between burst beats
//  BEAT_W     $clog2(BEATS_MAX+1)  width of beat counters (derived, localparam)
// PORTS
//  clk                input   1          clock, rising edge
//  reset              input   1          asynchronous, active-high
//  enable             input   1          0 = stall: all state and outputs hold
//  fetch_req          input   1          controller requests instruction fetch at PC
//  mem_req            input   1          controller requests data/branch access
//  mem_mode           input   2          00 none, 01 A+B single, 10 RFA single, 11 burst from A+B
//  beat_count         input   BEAT_W     burst length, sampled at mem_req accept
//  pc_value           input   ADDR_W     current PC
//  aplusb_value       input   ADDR_W     base+offset from ALU
//  rfa_value          input   ADDR_W     register-file port A (post-increment modes)
//  exception_pending  input   1          suppresses fetch; aborts burst
//  interrupt_pending  input   1          suppresses fetch only
//  bus_ack            input   1          bus accepted current address this cycle
//  addr_sel           output  3          0 NO_OP, 1 PC, 2 APLUSB, 3 RFA, 4 SEQ
//  addr_out           output  ADDR_W     registered address to bus
//  addr_valid         output  1          addr_out valid; held until bus_ack
//  beat_index         output  BEAT_W     index of current beat (0-based)
//  busy               output  1          sequencer not IDLE
//  done               output  1          1-cycle pulse: last beat acked or abort
//  aborted            output  1          1-cycle pulse with done when burst aborted
// BEHAVIOUR
//  Reset: state=IDLE; addr_sel=0; addr_out=0; addr_valid=0; beat_index=0;
//   busy=0; done=0; aborted=0. Takes effect immediately, including mid-burst.
//  Stall: when enable=0, no register updates, and bus_ack is ignored.
//   done and aborted hold their previous value.
//  All outputs are registered. A request accepted in cycle N drives outputs in N+1.
//  States: IDLE, SINGLE, BURST.
//  IDLE (enable=1):
//   - mem_req, mode 01 -> SINGLE, sel=2, addr=aplusb_value.
//   - mem_req, mode 10 -> SINGLE, sel=3, addr=rfa_value.
//   - mem_req, mode 11 -> BURST, sel=2, addr=aplusb_value,
//     len=max(1, min(beat_count, BEATS_MAX)).
//   - mem_req with mode 00 is ignored; the block stays in IDLE with sel=0.
//   - fetch_req with no exception_pending and no interrupt_pending -> SINGLE,
//     sel=1, addr=pc_value.
//   - fetch_req while exception_pending or interrupt_pending -> stays IDLE,
//     sel=0, no valid.
//   - mem_req and fetch_req together: mem_req wins; fetch_req is dropped and
//     the controller re-issues it.
//   - Any accept sets addr_valid=1, beat_index=0, busy=1.
//  SINGLE: holds addr/sel/valid until bus_ack. On ack: done=1, valid=0, sel=0,
//   then IDLE. exception_pending does not abort a single access already issued.
//  BURST: on each bus_ack with beat_index<len-1:
//   - addr_out += STRIDE (modulo 2^ADDR_W, wraps silently)
//   - beat_index+1, sel=4 (SEQ), valid stays 1.
//   On ack of beat len-1: done=1, valid=0, sel=0, then IDLE.
//   exception_pending in BURST, sampled before ack: the current beat completes
//   only if ack arrives in the same cycle; otherwise valid drops next cycle,
//   done=1, aborted=1, then IDLE.
//  Requests arriving while busy are ignored and are not queued.
//  After done, a new request is accepted in the same cycle the FSM re-enters IDLE.
//   This requires no dead cycle: done cycle + accept gives back-to-back access.
//  interrupt_pending has no effect on mem accesses or bursts.
// TESTING
//  1 fetch_req=1, pc=0x100, ack next cycle -> sel=1, addr=0x100, valid 1 cycle,
//    done pulse, then IDLE.
//  2 mem_req mode=11, beat_count=4, A+B=0x2000, ack every cycle ->
//    addr 0x2000/2004/2008/200C, sel 2,4,4,4, done on 4th ack.
//  3 burst beat_count=0 -> one beat; beat_count=15 with BEATS_MAX=8 -> 8 beats;
//    A+B=0xFFFF_FFFC with 2 beats -> second addr=0x0000_0000.
//  4 fetch_req with interrupt_pending=1 -> no valid, sel=0;
//    fetch_req+mem_req mode=10, rfa=0x40 -> sel=3, addr=0x40.
//  5 burst of 4: exception_pending after 2 acks with ack low -> valid falls,
//    done=1 and aborted=1 pulse, beat_index=2 at abort.
//  6 enable=0 for 3 cycles mid-burst with ack high -> addr/beat_index frozen;
//    reset asserted mid-burst -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/address_sequencer.sv
// address_sequencer: registered memory-address source for the cpu32e controller.
// Picks PC / A+B / RFA for single accesses and walks STRIDE-spaced burst beats
// under a valid/ack handshake. Supports stall (enable), exception abort and
// fetch suppression.
module address_sequencer #(
  parameter  int ADDR_W    = 32,
  parameter  int BEATS_MAX = 8,
  parameter  int STRIDE    = 4,
  localparam int BEAT_W    = $clog2(BEATS_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              fetch_req,
  input  logic              mem_req,
  input  logic [1:0]        mem_mode,
  input  logic [BEAT_W-1:0] beat_count,
  input  logic [ADDR_W-1:0] pc_value,
  input  logic [ADDR_W-1:0] aplusb_value,
  input  logic [ADDR_W-1:0] rfa_value,
  input  logic              exception_pending,
  input  logic              interrupt_pending,
  input  logic              bus_ack,
  output logic [2:0]        addr_sel,
  output logic [ADDR_W-1:0] addr_out,
  output logic              addr_valid,
  output logic [BEAT_W-1:0] beat_index,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SINGLE = 2'd1;
  localparam logic [1:0] S_BURST  = 2'd2;

  localparam logic [2:0] SEL_NOP = 3'd0;
  localparam logic [2:0] SEL_PC  = 3'd1;
  localparam logic [2:0] SEL_AB  = 3'd2;
  localparam logic [2:0] SEL_RFA = 3'd3;
  localparam logic [2:0] SEL_SEQ = 3'd4;

  localparam logic [BEAT_W-1:0] MAXB = BEAT_W'(BEATS_MAX);
  localparam logic [BEAT_W-1:0] ONE  = BEAT_W'(1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(STRIDE);

  logic [1:0]        state;
  logic [BEAT_W-1:0] len;
  logic [BEAT_W-1:0] len_clamp;
  logic              last_beat;

  // Burst length clamped to 1..BEATS_MAX; a zero request still moves one beat.
  always_comb begin
    len_clamp = beat_count;
    if (beat_count == '0)       len_clamp = ONE;
    else if (beat_count > MAXB) len_clamp = MAXB;
  end

  assign last_beat = (beat_index == len - ONE);

  // Sequencer FSM; every output is a register so the bus mux sees clean timing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      len        <= ONE;
      addr_sel   <= SEL_NOP;
      addr_out   <= '0;
      addr_valid <= 1'b0;
      beat_index <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      aborted    <= 1'b0;
    end else if (enable) begin
      case (state)
        S_IDLE: begin
          done     <= 1'b0;
          aborted  <= 1'b0;
          addr_sel <= SEL_NOP;
          // mode 00 is no request at all, so a concurrent fetch may still go
          if (mem_req && mem_mode != 2'b00) begin
            addr_valid <= 1'b1;
            beat_index <= '0;
            busy       <= 1'b1;
            case (mem_mode)
              2'b01: begin
                state    <= S_SINGLE;
                addr_sel <= SEL_AB;
                addr_out <= aplusb_value;
              end
              2'b10: begin
                state    <= S_SINGLE;
                addr_sel <= SEL_RFA;
                addr_out <= rfa_value;
              end
              default: begin
                state    <= S_BURST;
                addr_sel <= SEL_AB;
                addr_out <= aplusb_value;
                len      <= len_clamp;
              end
            endcase
          end else if (fetch_req && !exception_pending && !interrupt_pending) begin
            state      <= S_SINGLE;
            addr_sel   <= SEL_PC;
            addr_out   <= pc_value;
            addr_valid <= 1'b1;
            beat_index <= '0;
            busy       <= 1'b1;
          end
        end
        S_SINGLE: begin
          // an issued single access always runs to completion
          if (bus_ack) begin
            state      <= S_IDLE;
            done       <= 1'b1;
            addr_valid <= 1'b0;
            addr_sel   <= SEL_NOP;
            busy       <= 1'b0;
          end
        end
        S_BURST: begin
          if (bus_ack) begin
            if (last_beat) begin
              state      <= S_IDLE;
              done       <= 1'b1;
              addr_valid <= 1'b0;
              addr_sel   <= SEL_NOP;
              busy       <= 1'b0;
            end else begin
              addr_out   <= addr_out + STEP;
              beat_index <= beat_index + ONE;
              addr_sel   <= SEL_SEQ;
            end
          end else if (exception_pending) begin
            // beat not taken: drop it and report the abort
            state      <= S_IDLE;
            done       <= 1'b1;
            aborted    <= 1'b1;
            addr_valid <= 1'b0;
            addr_sel   <= SEL_NOP;
            busy       <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_address_sequencer.sv
// Self-checking bench for address_sequencer: expected beats are queued when a
// request is driven and compared as each beat is acknowledged.
module tb_address_sequencer;

  localparam int ADDR_W = 32;
  localparam int BEAT_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic              fetch_req, mem_req;
  logic [1:0]        mem_mode;
  logic [BEAT_W-1:0] beat_count;
  logic [ADDR_W-1:0] pc_value, aplusb_value, rfa_value;
  logic              exception_pending, interrupt_pending, bus_ack;
  logic [2:0]        addr_sel;
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid, busy, done, aborted;
  logic [BEAT_W-1:0] beat_index;

  typedef struct {
    logic [2:0]        sel;
    logic [ADDR_W-1:0] addr;
    logic [BEAT_W-1:0] idx;
  } beat_t;

  beat_t exp_q[$];
  int checks = 0;
  int errors = 0;

  address_sequencer #(.ADDR_W(32), .BEATS_MAX(8), .STRIDE(4)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .fetch_req(fetch_req), .mem_req(mem_req), .mem_mode(mem_mode),
    .beat_count(beat_count), .pc_value(pc_value), .aplusb_value(aplusb_value),
    .rfa_value(rfa_value), .exception_pending(exception_pending),
    .interrupt_pending(interrupt_pending), .bus_ack(bus_ack),
    .addr_sel(addr_sel), .addr_out(addr_out), .addr_valid(addr_valid),
    .beat_index(beat_index), .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  // advance one clock; returns 1 time unit after the edge with outputs settled
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beat(input logic [2:0] s, input logic [ADDR_W-1:0] a, input int i);
    beat_t b;
    b.sel = s; b.addr = a; b.idx = BEAT_W'(i);
    exp_q.push_back(b);
  endtask

  task automatic test_reset();
    checks++;
    if ({addr_sel, addr_out, addr_valid, beat_index, busy, done, aborted} !== '0) begin
      errors++;
      $display("FAIL reset_state: got sel=%0d addr=%h v=%b idx=%0d busy=%b done=%b ab=%b want all 0",
               addr_sel, addr_out, addr_valid, beat_index, busy, done, aborted);
    end
  endtask

  task automatic test_fetch();
    beat_t e;
    pc_value = 32'h100; fetch_req = 1'b1;
    push_beat(3'd1, 32'h100, 0);
    tick();
    fetch_req = 1'b0; bus_ack = 1'b1;
    checks++;
    if (exp_q.size() == 0 || addr_valid !== 1'b1) begin
      errors++; $display("FAIL fetch_valid: got valid=%b want 1", addr_valid);
    end else begin
      e = exp_q.pop_front();
      if (addr_sel !== e.sel || addr_out !== e.addr || beat_index !== e.idx) begin
        errors++;
        $display("FAIL fetch_beat: got sel=%0d addr=%h idx=%0d want sel=%0d addr=%h idx=%0d",
                 addr_sel, addr_out, beat_index, e.sel, e.addr, e.idx);
      end
    end
    tick();
    bus_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || addr_valid !== 1'b0 || addr_sel !== 3'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL fetch_done: got done=%b v=%b sel=%0d busy=%b want 1 0 0 0",
               done, addr_valid, addr_sel, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL fetch_done_pulse: got done=%b want 0", done); end
  endtask

  // burst from A+B with ack held high; nb is the expected number of beats
  task automatic test_burst(input logic [ADDR_W-1:0] base, input logic [BEAT_W-1:0] bc, input int nb);
    beat_t e;
    int n;
    aplusb_value = base; beat_count = bc; mem_mode = 2'b11; mem_req = 1'b1;
    for (int i = 0; i < nb; i++) push_beat((i == 0) ? 3'd2 : 3'd4, base + 32'(i * 4), i);
    tick();
    mem_req = 1'b0; bus_ack = 1'b1;
    n = 0;
    while (!done && n < 40) begin
      if (addr_valid && bus_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL burst_extra_beat: got addr=%h idx=%0d want no beat", addr_out, beat_index);
        end else begin
          e = exp_q.pop_front();
          if (addr_sel !== e.sel || addr_out !== e.addr || beat_index !== e.idx) begin
            errors++;
            $display("FAIL burst_beat: got sel=%0d addr=%h idx=%0d want sel=%0d addr=%h idx=%0d",
                     addr_sel, addr_out, beat_index, e.sel, e.addr, e.idx);
          end
        end
      end
      tick(); n++;
    end
    bus_ack = 1'b0;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b0 || addr_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL burst_end: got done=%b ab=%b v=%b left=%0d want 1 0 0 0",
               done, aborted, addr_valid, exp_q.size());
      exp_q.delete();
    end
    tick();
  endtask

  task automatic test_suppress();
    beat_t e;
    pc_value = 32'h200; fetch_req = 1'b1; interrupt_pending = 1'b1;
    tick();
    fetch_req = 1'b0; interrupt_pending = 1'b0;
    checks++;
    if (addr_valid !== 1'b0 || addr_sel !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL fetch_irq: got v=%b sel=%0d busy=%b want 0 0 0", addr_valid, addr_sel, busy);
    end
    fetch_req = 1'b1; mem_req = 1'b1; mem_mode = 2'b10; rfa_value = 32'h40;
    push_beat(3'd3, 32'h40, 0);
    tick();
    fetch_req = 1'b0; mem_req = 1'b0; bus_ack = 1'b1;
    checks++;
    e = exp_q.pop_front();
    if (addr_valid !== 1'b1 || addr_sel !== e.sel || addr_out !== e.addr) begin
      errors++;
      $display("FAIL mem_over_fetch: got v=%b sel=%0d addr=%h want 1 %0d %h", addr_valid, addr_sel, addr_out, e.sel, e.addr);
    end
    tick();
    bus_ack = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL rfa_done: got done=%b want 1", done); end
    tick();
  endtask

  task automatic test_abort();
    beat_t e;
    aplusb_value = 32'h3000; beat_count = 4'd4; mem_mode = 2'b11; mem_req = 1'b1;
    push_beat(3'd2, 32'h3000, 0); push_beat(3'd4, 32'h3004, 1);
    tick();
    mem_req = 1'b0; bus_ack = 1'b1;
    for (int k = 0; k < 2; k++) begin
      checks++;
      e = exp_q.pop_front();
      if (addr_valid !== 1'b1 || addr_sel !== e.sel || addr_out !== e.addr || beat_index !== e.idx) begin
        errors++;
        $display("FAIL abort_beat: got sel=%0d addr=%h idx=%0d want sel=%0d addr=%h idx=%0d",
                 addr_sel, addr_out, beat_index, e.sel, e.addr, e.idx);
      end
      tick();
    end
    bus_ack = 1'b0; exception_pending = 1'b1;
    tick();
    exception_pending = 1'b0;
    checks++;
    if (done !== 1'b1 || aborted !== 1'b1 || addr_valid !== 1'b0 || beat_index !== 4'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort: got done=%b ab=%b v=%b idx=%0d busy=%b want 1 1 0 2 0",
               done, aborted, addr_valid, beat_index, busy);
    end
    tick();
    checks++;
    if (done !== 1'b0 || aborted !== 1'b0) begin
      errors++; $display("FAIL abort_pulse: got done=%b ab=%b want 0 0", done, aborted);
    end
  endtask

  task automatic test_stall_reset();
    beat_t e;
    int n;
    aplusb_value = 32'h4000; beat_count = 4'd4; mem_mode = 2'b11; mem_req = 1'b1;
    for (int i = 0; i < 4; i++) push_beat((i == 0) ? 3'd2 : 3'd4, 32'h4000 + 32'(i * 4), i);
    tick();
    mem_req = 1'b0; bus_ack = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (addr_out !== e.addr || addr_sel !== e.sel) begin
      errors++; $display("FAIL stall_first: got addr=%h sel=%0d want %h %0d", addr_out, addr_sel, e.addr, e.sel);
    end
    tick();
    enable = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (addr_out !== 32'h4004 || beat_index !== 4'd1 || addr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: got addr=%h idx=%0d v=%b want 4004 1 1", addr_out, beat_index, addr_valid);
      end
    end
    enable = 1'b1;
    n = 0;
    while (!done && n < 20) begin
      if (addr_valid && bus_ack) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stall_extra: got addr=%h want no beat", addr_out);
        end else begin
          e = exp_q.pop_front();
          if (addr_sel !== e.sel || addr_out !== e.addr || beat_index !== e.idx) begin
            errors++;
            $display("FAIL stall_beat: got sel=%0d addr=%h idx=%0d want sel=%0d addr=%h idx=%0d",
                     addr_sel, addr_out, beat_index, e.sel, e.addr, e.idx);
          end
        end
      end
      tick(); n++;
    end
    checks++;
    if (done !== 1'b1 || exp_q.size() != 0) begin
      errors++; $display("FAIL stall_end: got done=%b left=%0d want 1 0", done, exp_q.size());
      exp_q.delete();
    end
    bus_ack = 1'b0;
    tick();
    // async reset in the middle of a burst
    aplusb_value = 32'h5000; mem_req = 1'b1;
    tick();
    mem_req = 1'b0; bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({addr_sel, addr_out, addr_valid, beat_index, busy, done, aborted} !== '0) begin
      errors++;
      $display("FAIL async_reset: got sel=%0d addr=%h v=%b idx=%0d busy=%b want all 0",
               addr_sel, addr_out, addr_valid, beat_index, busy);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    aplusb_value = 32'h600; mem_mode = 2'b01; mem_req = 1'b1;
    tick();
    mem_req = 1'b0;
    // request while busy must be ignored
    pc_value = 32'h999; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    checks++;
    if (addr_out !== 32'h600 || addr_sel !== 3'd2 || addr_valid !== 1'b1) begin
      errors++; $display("FAIL busy_ignore: got addr=%h sel=%0d v=%b want 600 2 1", addr_out, addr_sel, addr_valid);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL b2b_done: got done=%b want 1", done); end
    pc_value = 32'h700; fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    checks++;
    if (addr_valid !== 1'b1 || addr_sel !== 3'd1 || addr_out !== 32'h700 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_accept: got v=%b sel=%0d addr=%h done=%b want 1 1 700 0", addr_valid, addr_sel, addr_out, done);
    end
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; fetch_req = 1'b0; mem_req = 1'b0; mem_mode = 2'b00;
    beat_count = '0; pc_value = '0; aplusb_value = '0; rfa_value = '0;
    exception_pending = 1'b0; interrupt_pending = 1'b0; bus_ack = 1'b0;
    tick(); tick();
    test_reset();
    reset = 1'b0;
    tick();
    test_fetch();
    test_burst(32'h2000, 4'd4, 4);
    test_burst(32'h2100, 4'd0, 1);
    test_burst(32'h2200, 4'd15, 8);
    test_burst(32'hFFFF_FFFC, 4'd2, 2);
    test_suppress();
    test_abort();
    test_stall_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
